// File: rtl/cbya_seq_adder.sv
// cbya_seq_adder: byte-serial WIDTH-bit adder on one 8-bit carry-bypass slice; ports clk/rst, in_valid/in_ready/a/b/cin in, out_valid/out_ready/sum/cout/overflow/bp_mask out
module cbya_seq_adder #(
  parameter int WIDTH = 32,
  localparam int NBYTES = WIDTH / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic              cin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  sum,
  output logic              cout,
  output logic              overflow,
  output logic [NBYTES-1:0] bp_mask
);
  localparam int CW = NBYTES > 1 ? $clog2(NBYTES) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] a_r, b_r;
  logic [CW-1:0] cnt;
  logic carry, bypass, ripple_c, slice_c, last;
  logic [7:0] sa, sb, ss;
  assign sa = a_r[8*cnt +: 8];
  assign sb = b_r[8*cnt +: 8];
  assign bypass = &(sa ^ sb);
  assign {ripple_c, ss} = {1'b0, sa} + {1'b0, sb} + 9'(carry);
  assign slice_c = bypass ? carry : ripple_c;
  assign last = cnt == CW'(NBYTES - 1);
  assign in_ready = state == IDLE && !rst;
  assign out_valid = state == DONE;
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (in_valid ? RUN : IDLE)
            : state == RUN  ? (last ? DONE : RUN)
            : (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r      <= '0;
      b_r      <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      bp_mask  <= '0;
    end else if (state == IDLE && in_valid) begin
      a_r     <= a;
      b_r     <= b;
      carry   <= cin;
      cnt     <= '0;
      bp_mask <= '0;
    end else if (state == RUN) begin
      sum[8*cnt +: 8] <= ss;
      carry           <= slice_c;
      bp_mask[cnt]    <= bypass;
      cnt             <= last ? '0 : cnt + CW'(1);
      if (last) begin
        cout     <= slice_c;
        overflow <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (ss[7] != a_r[WIDTH-1]);
      end
    end
  end
endmodule

// File: tb/tb_cbya_seq_adder.sv
// tb_cbya_seq_adder: randomized and directed checks of cbya_seq_adder at WIDTH 32 and 8 against an arithmetic model
module tb_cbya_seq_adder;
  logic clk = 0, rst = 1;
  logic iv32 = 0, or32 = 0, cin32 = 0, ir32, ov32, co32, of32;
  logic [31:0] a32 = 0, b32 = 0, s32;
  logic [3:0] bp32;
  logic iv8 = 0, or8 = 0, cin8 = 0, ir8, ov8, co8, of8;
  logic [7:0] a8 = 0, b8 = 0, s8;
  logic [0:0] bp8;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  cbya_seq_adder #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32), .cin(cin32),
    .out_valid(ov32), .out_ready(or32), .sum(s32), .cout(co32), .overflow(of32), .bp_mask(bp32));
  cbya_seq_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .cin(cin8),
    .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8), .overflow(of8), .bp_mask(bp8));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic op32(input logic [31:0] av, input logic [31:0] bv, input logic cv,
                      input bit scramble, input int stall);
    logic [32:0] full;
    longint sv;
    logic ovf;
    logic [3:0] bp;
    int lat;
    full = {1'b0, av} + {1'b0, bv} + 33'(cv);
    sv = longint'($signed(av)) + longint'($signed(bv)) + longint'(cv);
    ovf = sv > 64'sd2147483647 || sv < -64'sd2147483648;
    for (int i = 0; i < 4; i++) bp[i] = (av[8*i +: 8] ^ bv[8*i +: 8]) == 8'hFF;
    a32 = av; b32 = bv; cin32 = cv; iv32 = 1; or32 = 0;
    chk("in_ready_idle32", 64'(ir32), 1);
    tick;
    iv32 = 0;
    lat = 0;
    while (!ov32 && lat < 20) begin
      if (scramble) begin a32 = $urandom; b32 = $urandom; cin32 = 1'($urandom); end
      tick;
      lat++;
    end
    chk("latency32", 64'(lat), 4);
    for (int i = 0; i < stall; i++) begin
      iv32 = 1; a32 = $urandom; b32 = $urandom;
      chk("stall_valid32", 64'(ov32), 1);
      chk("stall_ready32", 64'(ir32), 0);
      chk("stall_sum32", 64'({co32, s32}), 64'(full));
      tick;
    end
    or32 = 1;
    chk("sum_cout32", 64'({co32, s32}), 64'(full));
    chk("overflow32", 64'(of32), 64'(ovf));
    chk("bp_mask32", 64'(bp32), 64'(bp));
    tick;
    or32 = 0; iv32 = 0;
    chk("valid_drop32", 64'(ov32), 0);
    chk("ready_back32", 64'(ir32), 1);
    chk("hold_sum32", 64'({co32, s32}), 64'(full));
  endtask

  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic cv, input int stall);
    logic [8:0] full;
    longint sv;
    int lat;
    full = {1'b0, av} + {1'b0, bv} + 9'(cv);
    sv = longint'($signed(av)) + longint'($signed(bv)) + longint'(cv);
    a8 = av; b8 = bv; cin8 = cv; iv8 = 1; or8 = 0;
    tick;
    iv8 = 0;
    lat = 0;
    while (!ov8 && lat < 20) begin tick; lat++; end
    chk("latency8", 64'(lat), 1);
    for (int i = 0; i < stall; i++) begin
      chk("stall_valid8", 64'(ov8), 1);
      tick;
    end
    or8 = 1;
    chk("sum_cout8", 64'({co8, s8}), 64'(full));
    chk("overflow8", 64'(of8), 64'(sv > 127 || sv < -128));
    chk("bp_mask8", 64'(bp8), 64'((av ^ bv) == 8'hFF));
    tick;
    or8 = 0;
    chk("valid_drop8", 64'(ov8), 0);
  endtask

  initial begin
    tick;
    chk("ready_in_rst", 64'(ir32), 0);
    tick;
    rst = 0;
    #1;
    chk("rst_valid", 64'(ov32), 0);
    chk("rst_sum", 64'(s32), 0);
    chk("rst_flags", 64'({co32, of32, bp32}), 0);
    chk("rst_ready", 64'(ir32), 1);
    op32(32'hFFFFFFFF, 32'h00000001, 0, 0, 0);
    op32(32'h7FFFFFFF, 32'h00000001, 0, 0, 0);
    op32(32'h12345678, 32'h0F0F0F0F, 1, 1, 0);
    op32(32'h89ABCDEF, 32'h76543210, 1, 0, 5);
    op32(32'hDEADBEEF, 32'h21524110, 1, 0, 0);
    a32 = 32'hFFFFFFFF; b32 = 32'h00000001; cin32 = 0; iv32 = 1;
    tick;
    iv32 = 0;
    tick;
    rst = 1;
    tick;
    rst = 0;
    #1;
    chk("midrun_ready", 64'(ir32), 1);
    chk("midrun_sum", 64'(s32), 0);
    chk("midrun_flags", 64'({co32, bp32}), 0);
    for (int i = 0; i < 6; i++) begin
      chk("midrun_novalid", 64'(ov32), 0);
      tick;
    end
    op8(8'hFF, 8'h01, 0, 0);
    op8(8'h7F, 8'h00, 1, 2);
    for (int n = 0; n < 1000; n++)
      op32($urandom, $urandom, 1'($urandom), n % 4 == 0, $urandom_range(0, 3));
    for (int n = 0; n < 1000; n++)
      op8(8'($urandom), 8'($urandom), 1'($urandom), $urandom_range(0, 3));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
